// File: rtl/serial_add_sub_ctrl.sv
// Bit-serial add/subtract sequencer: one 1-bit cell plus a carry/borrow flag.
// Ports: clk, rst (sync, active-high), start/mode/a/b in; busy/done/result/carry_borrow out.
`timescale 1ns/1ps
module serial_add_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_borrow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_accept;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_part;
    logic [WIDTH-1:0] r_result;
    logic [CW-1:0]    r_cnt;
    logic             r_mode;
    logic             r_flag;
    logic             r_cb;

    logic             w_ai;
    logic             w_bi;
    logic             w_x;
    logic             w_s;
    logic             w_flag_nxt;
    logic             w_last;

    // 1-bit add/subtract cell; flag is carry in add mode, borrow in subtract
    assign w_ai = r_a[0];
    assign w_bi = r_b[0];
    assign w_x  = w_ai ^ w_bi;
    assign w_s  = w_x ^ r_flag;
    assign w_flag_nxt = r_mode ? ((~w_ai & w_bi) | (~w_x & r_flag))
                               : ((w_ai & w_bi) | (w_x & r_flag));
    assign w_last = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                // a start here re-enters RUN directly so no cycle is lost
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_part   <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_mode   <= 1'b0;
            r_flag   <= 1'b0;
            r_cb     <= 1'b0;
        end else if (w_accept) begin
            r_a    <= a;
            r_b    <= b;
            r_mode <= mode;
            r_part <= '0;
            r_flag <= 1'b0;
            r_cnt  <= '0;
        end else if (busy) begin
            r_a    <= r_a >> 1;
            r_b    <= r_b >> 1;
            r_part <= {w_s, r_part[WIDTH-1:1]};
            r_flag <= w_flag_nxt;
            // outputs only change once the last bit is in
            if (w_last) begin
                r_result <= {w_s, r_part[WIDTH-1:1]};
                r_cb     <= w_flag_nxt;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign result       = r_result;
    assign carry_borrow = r_cb;

endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
// Directed bench for serial_add_sub_ctrl at WIDTH=8.
// Each scenario task drives operands and compares outputs with hand-computed values.
`timescale 1ns/1ps
module tb_serial_add_sub_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_borrow;

    int n_cmp;
    int n_bad;

    serial_add_sub_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mode         (mode),
        .a            (a),
        .b            (b),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .carry_borrow (carry_borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic tm);
        a    = ta;
        b    = tb_v;
        mode = tm;
    endtask

    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tm);
        put(ta, tb_v, tm);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Bounded wait for done; reports cycles taken, busy count, result stability
    task automatic wait_done(input logic [W-1:0] hold, output int lat,
                             output int nbusy, output bit unstable,
                             output bit overlap, output bit tout);
        lat      = 0;
        nbusy    = 0;
        unstable = 1'b0;
        overlap  = 1'b0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) nbusy++;
            if (result !== hold) unstable = 1'b1;
            tick();
            lat++;
        end
        tout    = (done !== 1'b1);
        overlap = (busy === 1'b1);
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        put('0, '0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, carry_borrow} !== 3'b000 || result !== 8'h00) begin
            n_bad++;
            $display("FAIL reset: busy/done/cb=%b%b%b result=%h want 000 00",
                     busy, done, carry_borrow, result);
        end
    endtask

    task automatic test_add;
        int lat, nb;
        bit un, ov, to;
        launch(8'h3C, 8'h05, 1'b0);
        wait_done(8'h00, lat, nb, un, ov, to);
        n_cmp++;
        if (to || lat != W) begin
            n_bad++;
            $display("FAIL add_latency: got %0d want %0d", lat, W);
        end
        n_cmp++;
        if (nb != W || ov) begin
            n_bad++;
            $display("FAIL add_busy: count %0d overlap %0b want %0d 0", nb, ov, W);
        end
        n_cmp++;
        if (result !== 8'h41 || carry_borrow !== 1'b0) begin
            n_bad++;
            $display("FAIL add_3C_05: got %h/%b want 41/0", result, carry_borrow);
        end
        n_cmp++;
        if (un) begin
            n_bad++;
            $display("FAIL add_hold: result changed before done, want stable 00");
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL add_pulse: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_wrap;
        int lat, nb;
        bit un, ov, to;
        launch(8'hFF, 8'h01, 1'b0);
        wait_done(8'h41, lat, nb, un, ov, to);
        n_cmp++;
        if (to || result !== 8'h00 || carry_borrow !== 1'b1) begin
            n_bad++;
            $display("FAIL add_FF_01: got %h/%b want 00/1", result, carry_borrow);
        end
        n_cmp++;
        if (un) begin
            n_bad++;
            $display("FAIL wrap_hold: result changed before done, want stable 41");
        end
        tick();
        launch(8'h05, 8'h03, 1'b1);
        wait_done(8'h00, lat, nb, un, ov, to);
        n_cmp++;
        if (to || result !== 8'h02 || carry_borrow !== 1'b0) begin
            n_bad++;
            $display("FAIL sub_05_03: got %h/%b want 02/0", result, carry_borrow);
        end
        tick();
    endtask

    task automatic test_sub;
        int lat, nb;
        bit un, ov, to;
        launch(8'h03, 8'h05, 1'b1);
        wait_done(8'h02, lat, nb, un, ov, to);
        n_cmp++;
        if (to || result !== 8'hFE || carry_borrow !== 1'b1) begin
            n_bad++;
            $display("FAIL sub_03_05: got %h/%b want FE/1", result, carry_borrow);
        end
        tick();
        launch(8'h00, 8'h00, 1'b1);
        wait_done(8'hFE, lat, nb, un, ov, to);
        n_cmp++;
        if (to || result !== 8'h00 || carry_borrow !== 1'b0) begin
            n_bad++;
            $display("FAIL sub_00_00: got %h/%b want 00/0", result, carry_borrow);
        end
        tick();
    endtask

    task automatic test_ignored_start;
        int lat, nb, pulses;
        bit un, ov, to;
        launch(8'h10, 8'h20, 1'b0);
        tick();
        tick();
        // third RUN cycle: this request must be ignored
        put(8'hFF, 8'hFF, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(8'h00, lat, nb, un, ov, to);
        n_cmp++;
        if (to || lat != W - 3) begin
            n_bad++;
            $display("FAIL ign_latency: got %0d want %0d", lat, W - 3);
        end
        n_cmp++;
        if (result !== 8'h30 || carry_borrow !== 1'b0) begin
            n_bad++;
            $display("FAIL ign_result: got %h/%b want 30/0", result, carry_borrow);
        end
        pulses = 0;
        for (int i = 0; i < 2 * W; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL ign_extra: got %0d extra busy/done cycles want 0", pulses);
        end
    endtask

    task automatic test_reset_mid;
        int lat, nb;
        bit un, ov, to;
        launch(8'hAA, 8'h55, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, carry_borrow} !== 3'b000 || result !== 8'h00) begin
            n_bad++;
            $display("FAIL rst_mid: busy/done/cb=%b%b%b result=%h want 000 00",
                     busy, done, carry_borrow, result);
        end
        put(8'h01, 8'h01, 1'b0);
        start = 1'b1;
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_vs_start: busy=%b want 0", busy);
        end
        launch(8'h01, 8'h01, 1'b0);
        wait_done(8'h00, lat, nb, un, ov, to);
        n_cmp++;
        if (to || lat != W || result !== 8'h02 || carry_borrow !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_restart: got %h/%b lat %0d want 02/0 lat %0d",
                     result, carry_borrow, lat, W);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] oa [3];
        logic [W-1:0] ob [3];
        logic         om [3];
        logic [W-1:0] er [3];
        logic         ec [3];
        logic [W-1:0] hold;
        int lat, nb;
        bit un, ov, to;
        oa = '{8'h12, 8'h10, 8'h80};
        ob = '{8'h34, 8'h20, 8'h80};
        om = '{1'b0, 1'b1, 1'b0};
        er = '{8'h46, 8'hF0, 8'h00};
        ec = '{1'b0, 1'b1, 1'b1};
        hold = 8'h02;
        put(oa[0], ob[0], om[0]);
        start = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) put(oa[i+1], ob[i+1], om[i+1]);
            wait_done(hold, lat, nb, un, ov, to);
            n_cmp++;
            if (to || lat != W || nb != W || ov) begin
                n_bad++;
                $display("FAIL b2b_timing[%0d]: lat %0d busy %0d ov %0b want %0d %0d 0",
                         i, lat, nb, ov, W, W);
            end
            n_cmp++;
            if (result !== er[i] || carry_borrow !== ec[i] || un) begin
                n_bad++;
                $display("FAIL b2b_result[%0d]: got %h/%b unstable %0b want %h/%b 0",
                         i, result, carry_borrow, un, er[i], ec[i]);
            end
            hold = er[i];
            if (i == 2) start = 1'b0;
            tick();
        end
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00) begin
            n_bad++;
            $display("FAIL b2b_end: busy=%b done=%b result=%h want 0 0 00",
                     busy, done, result);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        a     = '0;
        b     = '0;
        test_reset();
        test_add();
        test_wrap();
        test_sub();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
